rng_bounded_sampler: RTL and testbench

Consumer end of the random-word stream produced by the stochsuite generators (lcg and siblings). It takes a request carrying a bound N and draws 32-bit words from a generator. It returns one unbiased value in [0, N) using Lemire multiply-and-reject, and reports how many words it discarded. It sits between any `rnd` source and the stochastic kernels that need bounded integers.

---
 rtl/rng_bounded_sampler_pkg.sv | 24 ++
 rtl/restoring_mod.sv | 71 +++++++
 rtl/rng_bounded_sampler.sv | 114 +++++++++++
 tb/tb_rng_bounded_sampler.sv | 218 +++++++++++++++++++++
 4 files changed

// File: rtl/rng_bounded_sampler_pkg.sv
// Shared definitions for bounded random-integer consumers: word width, FSM encoding
// and the N=0 full-range convention.
package rng_bounded_sampler_pkg;

  localparam int unsigned RngW = 32;

  typedef enum logic [1:0] {
    StIdle   = 2'd0,
    StDiv    = 2'd1,
    StSample = 2'd2,
    StOut    = 2'd3
  } rng_state_e;

  // A bound of zero selects the full 2^32 range; the raw word is returned untouched.
  function automatic logic is_full_range(input logic [RngW-1:0] bound);
    return bound == '0;
  endfunction

  // Bounds 0 and 1 never reject, so their threshold is zero and no division is needed.
  function automatic logic needs_div(input logic [RngW-1:0] bound);
    return bound > RngW'(1);
  endfunction

endpackage

// File: rtl/restoring_mod.sv
// Restoring remainder engine: one quotient bit per cycle, W cycles per operation.
// The divisor must be held stable from the cycle after start until done.
module restoring_mod #(
  parameter int unsigned W = 32
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         start,
  input  logic [W-1:0] dividend,
  input  logic [W-1:0] divisor,
  output logic         done,
  output logic [W-1:0] remainder
);

  localparam int unsigned CntW = $clog2(W);

  logic [W-1:0]    rem_q, rem_d;
  logic [W-1:0]    dvd_q, dvd_d;
  logic [CntW-1:0] cnt_q, cnt_d;
  logic            busy_q, busy_d;
  logic [W:0]      shifted;
  logic [W:0]      diff;
  logic            last;

  // Partial remainder can exceed the divisor by one bit, so compare at W+1 bits.
  assign shifted = {rem_q, dvd_q[W-1]};
  assign diff    = shifted - {1'b0, divisor};
  assign last    = busy_q && (cnt_q == CntW'(W - 1));

  always_comb begin
    rem_d  = rem_q;
    dvd_d  = dvd_q;
    cnt_d  = cnt_q;
    busy_d = busy_q;
    if (start) begin
      rem_d  = '0;
      dvd_d  = dividend;
      cnt_d  = '0;
      busy_d = 1'b1;
    end else if (busy_q) begin
      dvd_d = {dvd_q[W-2:0], 1'b0};
      if (shifted >= {1'b0, divisor}) begin
        rem_d = diff[W-1:0];
      end else begin
        rem_d = shifted[W-1:0];
      end
      cnt_d = cnt_q + 1'b1;
      if (last) begin
        busy_d = 1'b0;
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rem_q  <= '0;
      dvd_q  <= '0;
      cnt_q  <= '0;
      busy_q <= 1'b0;
    end else begin
      rem_q  <= rem_d;
      dvd_q  <= dvd_d;
      cnt_q  <= cnt_d;
      busy_q <= busy_d;
    end
  end

  assign done      = last;
  assign remainder = rem_q;

endmodule

// File: rtl/rng_bounded_sampler.sv
// Maps a stream of 32-bit random words to unbiased integers in [0, N) using
// Lemire multiply-and-reject, reporting how many words were discarded.
module rng_bounded_sampler
  import rng_bounded_sampler_pkg::*;
#(
  parameter int unsigned REJ_CNT_W = 8
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 req_valid,
  output logic                 req_ready,
  input  logic [RngW-1:0]      req_bound,
  input  logic [RngW-1:0]      rnd_in,
  input  logic                 rnd_valid,
  output logic                 rnd_ready,
  output logic                 out_valid,
  input  logic                 out_ready,
  output logic [RngW-1:0]      out_data,
  output logic [REJ_CNT_W-1:0] out_rejects
);

  rng_state_e state_q, state_d;

  logic [RngW-1:0]      bound_q, bound_d;
  logic [RngW-1:0]      data_q, data_d;
  logic [REJ_CNT_W-1:0] rej_q, rej_d;
  logic [RngW-1:0]      thresh;
  logic [RngW-1:0]      div_rem;
  logic [RngW-1:0]      div_dividend;
  logic                 div_start;
  logic                 div_done;
  logic                 accept;
  logic [2*RngW-1:0]    prod;

  assign prod = {{RngW{1'b0}}, rnd_in} * {{RngW{1'b0}}, bound_q};

  // The engine remainder is only meaningful for bounds that went through DIV.
  assign thresh = needs_div(bound_q) ? div_rem : '0;
  assign accept = is_full_range(bound_q) || (prod[RngW-1:0] >= thresh);

  // (2^32 - N) mod N == (-N mod 2^32) mod N
  assign div_dividend = '0 - req_bound;
  assign div_start    = (state_q == StIdle) && req_valid && needs_div(req_bound);

  restoring_mod #(
    .W(RngW)
  ) u_restoring_mod (
    .clk      (clk),
    .rst_n    (rst_n),
    .start    (div_start),
    .dividend (div_dividend),
    .divisor  (bound_q),
    .done     (div_done),
    .remainder(div_rem)
  );

  always_comb begin
    state_d = state_q;
    bound_d = bound_q;
    data_d  = data_q;
    rej_d   = rej_q;
    unique case (state_q)
      StIdle: begin
        if (req_valid) begin
          bound_d = req_bound;
          rej_d   = '0;
          state_d = needs_div(req_bound) ? StDiv : StSample;
        end
      end
      StDiv: begin
        if (div_done) begin
          state_d = StSample;
        end
      end
      StSample: begin
        if (rnd_valid) begin
          if (accept) begin
            data_d  = is_full_range(bound_q) ? rnd_in : prod[2*RngW-1:RngW];
            state_d = StOut;
          end else if (rej_q != '1) begin
            rej_d = rej_q + 1'b1;
          end
        end
      end
      StOut: begin
        if (out_ready) begin
          state_d = StIdle;
        end
      end
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= StIdle;
      bound_q <= '0;
      data_q  <= '0;
      rej_q   <= '0;
    end else begin
      state_q <= state_d;
      bound_q <= bound_d;
      data_q  <= data_d;
      rej_q   <= rej_d;
    end
  end

  assign req_ready   = (state_q == StIdle);
  assign rnd_ready   = (state_q == StSample);
  assign out_valid   = (state_q == StOut);
  assign out_data    = data_q;
  assign out_rejects = rej_q;

endmodule

// File: tb/tb_rng_bounded_sampler.sv
// Directed bench for rng_bounded_sampler: latency, reject counting, backpressure,
// asynchronous reset mid-division and a long run fed by an LCG word source.
module tb_rng_bounded_sampler;

  localparam logic [31:0] LcgA  = 32'd1664525;
  localparam logic [31:0] LcgC  = 32'd1013904223;
  localparam logic [31:0] Seed0 = 32'h0000_0001;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        req_valid = 1'b0;
  logic        req_ready;
  logic [31:0] req_bound = '0;
  logic [31:0] rnd_in = '0;
  logic        rnd_valid = 1'b1;
  logic        rnd_ready;
  logic        out_valid;
  logic        out_ready = 1'b0;
  logic [31:0] out_data;
  logic [7:0]  out_rejects;

  int checks = 0;
  int errors = 0;
  int proto_err = 0;

  logic [31:0] words[3];
  int          widx;

  logic        prev_hold = 1'b0;
  logic [31:0] prev_data = '0;

  rng_bounded_sampler #(
    .REJ_CNT_W(8)
  ) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .req_valid  (req_valid),
    .req_ready  (req_ready),
    .req_bound  (req_bound),
    .rnd_in     (rnd_in),
    .rnd_valid  (rnd_valid),
    .rnd_ready  (rnd_ready),
    .out_valid  (out_valid),
    .out_ready  (out_ready),
    .out_data   (out_data),
    .out_rejects(out_rejects)
  );

  always #5 clk = ~clk;

  // Handshake outputs must be mutually exclusive; a held result must not move.
  always @(negedge clk) begin
    if (!rst_n) begin
      prev_hold = 1'b0;
    end else begin
      if ($countones({req_ready, rnd_ready, out_valid}) > 1) proto_err++;
      if (prev_hold && (!out_valid || out_data !== prev_data)) proto_err++;
      prev_hold = out_valid && !out_ready;
      prev_data = out_data;
    end
  end

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got 0x%08h expected 0x%08h", tag, got, exp);
    end
  endtask

  task automatic issue(input logic [31:0] bound);
    int n = 0;
    while (!req_ready && n < 100) begin
      @(posedge clk);
      #1;
      n++;
    end
    if (!req_ready) check_eq("req_ready_timeout", 32'(req_ready), 32'd1);
    req_bound = bound;
    req_valid = 1'b1;
    @(posedge clk);
    #1;
    req_valid = 1'b0;
  endtask

  // Returns k such that out_valid is first seen in cycle T+k.
  task automatic wait_out(output int lat);
    logic consume;
    lat = 1;
    while (!out_valid && lat < 200) begin
      consume = rnd_ready && rnd_valid;
      @(posedge clk);
      #1;
      lat++;
      if (consume && widx < 2) begin
        widx++;
        rnd_in = words[widx];
      end
    end
  endtask

  task automatic drain(input string tag);
    out_ready = 1'b1;
    @(posedge clk);
    #1;
    out_ready = 1'b0;
    check_eq({tag, "_req_ready"}, 32'(req_ready), 32'd1);
  endtask

  task automatic run(input string tag, input logic [31:0] bound, input logic [31:0] w0,
                     input logic [31:0] w1, input logic [31:0] w2, input logic [31:0] exp_data,
                     input logic [31:0] exp_rej, input int exp_lat, input int hold);
    int lat;
    words[0] = w0;
    words[1] = w1;
    words[2] = w2;
    widx     = 0;
    rnd_in   = w0;
    issue(bound);
    wait_out(lat);
    check_eq({tag, "_lat"}, 32'(lat), 32'(exp_lat));
    check_eq({tag, "_data"}, out_data, exp_data);
    check_eq({tag, "_rej"}, 32'(out_rejects), exp_rej);
    for (int i = 0; i < hold; i++) begin
      @(posedge clk);
      #1;
      check_eq({tag, "_hold_flags"}, 32'({out_valid, req_ready, rnd_ready}), 32'b100);
      check_eq({tag, "_hold_data"}, out_data, exp_data);
    end
    drain(tag);
  endtask

  task automatic check_reset_outputs(input string tag);
    check_eq({tag, "_req_ready"}, 32'(req_ready), 32'd1);
    check_eq({tag, "_rnd_ready"}, 32'(rnd_ready), 32'd0);
    check_eq({tag, "_out_valid"}, 32'(out_valid), 32'd0);
    check_eq({tag, "_out_data"}, out_data, 32'd0);
    check_eq({tag, "_out_rej"}, 32'(out_rejects), 32'd0);
  endtask

  initial begin
    logic [31:0] lcg;
    logic [31:0] exp_val;
    logic [31:0] x;
    logic [63:0] m;
    logic        consume;
    int          lat;

    #3;
    check_reset_outputs("por");
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk);
    #1;
    check_reset_outputs("post_rst");

    run("n0", 32'd0, 32'hDEADBEEF, 32'h0, 32'h0, 32'hDEADBEEF, 32'd0, 2, 0);
    run("n1", 32'd1, 32'h12345678, 32'h0, 32'h0, 32'd0, 32'd0, 2, 0);
    run("n10", 32'd10, 32'h0, 32'h1999999A, 32'hFFFFFFFF, 32'd9, 32'd2, 36, 0);

    // Abort a division at T+10; out_data still holds 9 from the previous sample.
    words[0] = 32'h0;
    words[1] = 32'h1999999A;
    words[2] = 32'hFFFFFFFF;
    widx     = 0;
    rnd_in   = words[0];
    issue(32'd10);
    repeat (9) begin
      @(posedge clk);
      #1;
    end
    #2;
    rst_n = 1'b0;
    #1;
    check_reset_outputs("mid_div_rst");
    @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk);
    #1;

    run("n10_again", 32'd10, 32'h0, 32'h1999999A, 32'hFFFFFFFF, 32'd9, 32'd2, 36, 0);
    run("n2p31", 32'h80000000, 32'hFFFFFFFF, 32'h0, 32'h0, 32'h7FFFFFFF, 32'd0, 34, 0);
    run("bp_n3", 32'd3, 32'h0, 32'h55555555, 32'h55555555, 32'd0, 32'd1, 35, 5);

    // Free-running LCG source with gaps in rnd_valid; for N=6 the threshold is 4.
    lcg = Seed0;
    rnd_in = lcg;
    for (int r = 0; r < 1000; r++) begin
      issue(32'd6);
      exp_val = 32'hFFFF_FFFF;
      lat = 1;
      while (!out_valid && lat < 400) begin
        rnd_valid = ($urandom_range(3) != 0);
        consume   = rnd_ready && rnd_valid;
        x         = rnd_in;
        @(posedge clk);
        #1;
        lat++;
        if (consume) begin
          m = {32'h0, x} * 64'd6;
          if (m[31:0] >= 32'd4) exp_val = m[63:32];
        end
        lcg    = lcg * LcgA + LcgC;
        rnd_in = lcg;
      end
      check_eq("lcg_val", out_data, exp_val);
      check_eq("lcg_range", 32'(out_data < 32'd6), 32'd1);
      drain("lcg");
    end
    rnd_valid = 1'b1;

    check_eq("protocol", 32'(proto_err), 32'd0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
